cdc_fifo_wr_arbiter: RTL and testbench
======================================

// Module: cdc_fifo_wr_arbiter
// PURPOSE
//  Shares the write port of one async Gray-pointer FIFO among NUM_REQ requesters in the write-clock domain.
//  Round-robin arbitration with packet lock: a grant is held from first beat to last beat, so packets never interleave in the FIFO.
//  Sits directly in front of the FIFO write side: clk is the FIFO wr_clk, and wr_en/wr_data/wr_full connect 1:1.
// PARAMETERS
//  NUM_REQ        4   number of requesters, >=2
//  DATA_WIDTH     8   beat width, equals FIFO DATA_WIDTH
//  MAX_PKT_BEATS  16  beats per packet before a forced release, >=1
// PORTS
//  clk         in   1                    write-domain clock (FIFO wr_clk)
//  rst_n       in   1                    asynchronous, active-low reset
//  req_valid   in   NUM_REQ              per-requester beat valid
//  req_last    in   NUM_REQ              per-requester last beat of packet, qualified by req_valid
//  req_data    in   NUM_REQ*DATA_WIDTH   requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
//  req_ready   out  NUM_REQ              beat accepted when req_valid[i] && req_ready[i]
//  wr_en       out  1                    FIFO write strobe
//  wr_data     out  DATA_WIDTH           FIFO write data
//  wr_full     in   1                    FIFO full flag, write domain
//  gnt_id      out  $clog2(NUM_REQ)      current or last owner index
//  busy        out  1                    high while a grant is locked
//  pkt_err     out  1                    1-cycle pulse on forced release at MAX_PKT_BEATS
// BEHAVIOUR
//  Reset values: state=ARB_IDLE, busy=0, pkt_err=0, req_ready=0, wr_en=0, beat_cnt=0, gnt_id=NUM_REQ-1.
//  Because gnt_id resets to NUM_REQ-1, requester 0 wins first after reset.
//  FSM: ARB_IDLE, ARB_LOCKED.
//  ARB_IDLE
//   - If any req_valid is high, pick the first valid index searching upward from gnt_id+1 (mod NUM_REQ).
//   - Register the pick into gnt_id, clear beat_cnt, go to ARB_LOCKED.
//   - Arbitration latency is 1 cycle; no beat is accepted in ARB_IDLE.
//  ARB_LOCKED
//   - req_ready[gnt_id] = !wr_full; all other req_ready bits = 0. Combinational.
//   - accept = req_valid[gnt_id] && !wr_full. wr_en = accept (combinational, never asserted while wr_full).
//   - wr_data = req_data slice of gnt_id, muxed every cycle.
//   - Each accept increments beat_cnt; beat_cnt width is $clog2(MAX_PKT_BEATS+1).
//   - accept && req_last[gnt_id]: go to ARB_IDLE next cycle; gnt_id keeps the owner as the round-robin pointer.
//   - accept && !last && beat_cnt+1==MAX_PKT_BEATS: forced release to ARB_IDLE and pkt_err=1 for one cycle.
//     The remainder of that packet re-arbitrates later; the requester is not dropped.
//   - Owner drops req_valid mid-packet: grant is held indefinitely; no timeout.
//   - wr_full during the last beat: no accept, stay in ARB_LOCKED; the beat is retried.
//  Boundaries
//   - Only one requester valid: back-to-back packets cost 1 idle cycle between them.
//   - All requesters valid: grants rotate 0,1,2,3,0 over successive packets.
//   - MAX_PKT_BEATS=1: every non-last beat pulses pkt_err.
//   - rst_n asserted mid-packet: immediate return to reset values; the partial packet already in the FIFO is not tracked.
//  busy = (state==ARB_LOCKED). Non-owner data and last inputs are ignored.
// STRUCTURE
//  Package cdc_arb_pkg holds:
//   - typedef enum logic [0:0] {ARB_IDLE, ARB_LOCKED} arb_state_e
//   - function rr_next_idx for the wrap arithmetic
//  Sub-module cdc_rr_pick: combinational round-robin picker.
//   - Inputs: req vector, last pointer. Outputs: pick index, any.
//   - Reused by the read-side scheduler.
//  Top level holds the FSM, beat counter, data mux and handshake logic.
// TESTING
//  T1 reset: rst_n low with all req_valid=1 -> busy=0, wr_en=0, req_ready=0; after release, first grant gnt_id=0.
//  T2 fairness: 4 requesters each send a 3-beat packet continuously
//   -> FIFO order 0,1,2,3,0 with no interleaving; 4 cycles per packet (1 arbitration + 3 beats).
//  T3 backpressure: wr_full=1 for 5 cycles during beat 2 of 3
//   -> wr_en=0 and req_ready=0 for those 5 cycles; beat 2 written exactly once after wr_full drops.
//  T4 forced release: MAX_PKT_BEATS=4, requester 1 sends 6 beats
//   -> pkt_err pulses on beat 4, busy drops, beats 5-6 are granted later; 6 writes in total.
//  T5 stall: owner drops req_valid for 10 cycles mid-packet while requester 2 is valid
//   -> requester 2 sees req_ready=0 throughout; owner completes the packet, then requester 2 is granted.
//  T6 reset mid-packet: rst_n pulsed low after beat 1 -> all outputs at reset values within the same cycle; next grant goes to requester 0.

Source files
------------

// File: rtl/cdc_arb_pkg.sv
// rtl/cdc_arb_pkg.sv - shared types and ring arithmetic for the FIFO write arbiter
package cdc_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Next index in a ring of n entries; n-1 wraps back to 0.
  function automatic int rr_next_idx(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cdc_rr_pick.sv
// rtl/cdc_rr_pick.sv - combinational round-robin picker starting after the last owner
module cdc_rr_pick import cdc_arb_pkg::*; #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last_ptr,
  output logic [$clog2(N)-1:0] pick,
  output logic                 any
);

  localparam int IW = $clog2(N);

  // Walk the ring once, starting one past last_ptr; the first requester found wins.
  always_comb begin
    int            idx;
    logic [IW-1:0] idx_v;
    pick  = '0;
    any   = 1'b0;
    idx   = int'(last_ptr);
    idx_v = last_ptr;
    for (int k = 0; k < N; k++) begin
      idx   = rr_next_idx(idx, N);
      idx_v = IW'(idx);
      if (!any && req[idx_v]) begin
        any  = 1'b1;
        pick = idx_v;
      end
    end
  end

endmodule

// File: rtl/cdc_fifo_wr_arbiter.sv
// rtl/cdc_fifo_wr_arbiter.sv - packet-locked round-robin arbiter for an async FIFO write port
module cdc_fifo_wr_arbiter import cdc_arb_pkg::*; #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int MAX_PKT_BEATS = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          wr_en,
  output logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          wr_full,
  output logic [$clog2(NUM_REQ)-1:0]    gnt_id,
  output logic                          busy,
  output logic                          pkt_err
);

  localparam int            IW         = $clog2(NUM_REQ);
  localparam int            CW         = $clog2(MAX_PKT_BEATS + 1);
  localparam logic [CW-1:0] BEAT_LIMIT = CW'(MAX_PKT_BEATS);
  localparam logic [IW-1:0] GNT_RST    = IW'(NUM_REQ - 1);

  arb_state_e    state;
  arb_state_e    state_nxt;
  logic [IW-1:0] gnt_nxt;
  logic [CW-1:0] beat_cnt;
  logic [CW-1:0] beat_cnt_nxt;
  logic [CW-1:0] beat_inc;
  logic          pkt_err_nxt;
  logic [IW-1:0] pick;
  logic          pick_any;
  logic          accept;
  logic          own_valid;
  logic          own_last;

  cdc_rr_pick #(.N(NUM_REQ)) u_pick (
    .req      (req_valid),
    .last_ptr (gnt_id),
    .pick     (pick),
    .any      (pick_any)
  );

  // Owner's lane of the request bus; the data mux runs every cycle regardless of state.
  always_comb begin
    own_valid = req_valid[gnt_id];
    own_last  = req_last[gnt_id];
    wr_data   = req_data[gnt_id*DATA_WIDTH +: DATA_WIDTH];
    beat_inc  = beat_cnt + CW'(1);
  end

  // Next-state, handshake and forced-release decisions.
  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt_id;
    beat_cnt_nxt = beat_cnt;
    pkt_err_nxt  = 1'b0;
    req_ready    = '0;
    accept       = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (pick_any) begin
          gnt_nxt      = pick;
          beat_cnt_nxt = '0;
          state_nxt    = ARB_LOCKED;
        end
      end
      ARB_LOCKED: begin
        req_ready[gnt_id] = !wr_full;
        accept            = own_valid && !wr_full;
        if (accept) begin
          beat_cnt_nxt = beat_inc;
          if (own_last) begin
            state_nxt = ARB_IDLE;
          end else if (beat_inc == BEAT_LIMIT) begin
            // Over-long packet: release the port; the owner keeps its remaining beats.
            state_nxt   = ARB_IDLE;
            pkt_err_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  assign wr_en = accept;
  assign busy  = (state == ARB_LOCKED);

  // State, owner pointer, beat counter and error pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB_IDLE;
      gnt_id   <= GNT_RST;
      beat_cnt <= '0;
      pkt_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      gnt_id   <= gnt_nxt;
      beat_cnt <= beat_cnt_nxt;
      pkt_err  <= pkt_err_nxt;
    end
  end

endmodule

// File: tb/tb_cdc_fifo_wr_arbiter.sv
// tb/tb_cdc_fifo_wr_arbiter.sv - scoreboard bench for the packet-locked FIFO write arbiter
module tb_cdc_fifo_wr_arbiter;

  localparam int NR   = 4;
  localparam int DW   = 8;
  localparam int MAXB = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_last;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic              wr_en;
  logic [DW-1:0]     wr_data;
  logic              wr_full;
  logic [1:0]        gnt_id;
  logic              busy;
  logic              pkt_err;

  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  d;
  } wlog_t;

  logic [8:0]    src_q [NR][$];
  logic [8:0]    exp_q [NR][$];
  logic [8:0]    last_pkt [$];
  wlog_t         wlog [$];
  logic [NR-1:0] hs;
  logic [NR-1:0] en_mask;
  int            valid_pct;
  int            full_pct;
  logic          full_ctl;
  int            cyc;
  int            err_seen;
  int            n_chk;
  int            n_pass;

  int            m_owner;
  int            m_cnt;
  logic          m_locked;
  logic          m_err;

  cdc_fifo_wr_arbiter #(
    .NUM_REQ       (NR),
    .DATA_WIDTH    (DW),
    .MAX_PKT_BEATS (MAXB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .wr_full   (wr_full),
    .gnt_id    (gnt_id),
    .busy      (busy),
    .pkt_err   (pkt_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Queue one packet on requester id; the top two data bits carry the id.
  task automatic send_pkt(input int id, input int len);
    logic [8:0] b;
    last_pkt.delete();
    for (int k = 0; k < len; k++) begin
      b = {(k == len - 1), 2'(id), 6'($urandom)};
      src_q[id].push_back(b);
      exp_q[id].push_back(b);
      last_pkt.push_back(b);
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NR; i++) if (src_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_writes(input int n, input int budget, input string tag);
    int t = 0;
    while (wlog.size() < n && t < budget) begin
      @(negedge clk); #1;
      t++;
    end
    check({tag, "_timeout"}, 32'(wlog.size() >= n), 32'd1);
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int t = 0;
    while (!(all_empty() && !m_locked) && t < budget) begin
      @(negedge clk); #1;
      t++;
    end
    check({tag, "_drain_timeout"}, 32'(all_empty() && !m_locked), 32'd1);
    repeat (2) @(negedge clk);
    #1;
  endtask

  // Requester drivers: retire handshaken beats, then present the next beat of each queue.
  initial begin
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    wr_full   = 1'b0;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++) begin
        if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0 && en_mask[i] && ($urandom_range(99) < valid_pct)) begin
          req_valid[i]           = 1'b1;
          req_data[i*DW +: DW]   = src_q[i][0][7:0];
          req_last[i]            = src_q[i][0][8];
        end else begin
          req_valid[i]           = 1'b0;
          req_data[i*DW +: DW]   = 8'($urandom);
          req_last[i]            = 1'($urandom);
        end
      end
      wr_full = full_ctl || ($urandom_range(99) < full_pct);
    end
  end

  // Monitor and reference model: predicts owner, handshake and data from the arbitration rules.
  initial begin
    logic [NR-1:0] er;
    logic          ew;
    logic [8:0]    e;
    bit            found;
    cyc      = 0;
    err_seen = 0;
    hs       = '0;
    m_locked = 1'b0;
    m_owner  = NR - 1;
    m_cnt    = 0;
    m_err    = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      hs = req_valid & req_ready;
      if (wr_en) wlog.push_back({32'(cyc), wr_data});
      if (pkt_err) err_seen++;
      if (!rst_n) begin
        m_locked = 1'b0;
        m_owner  = NR - 1;
        m_cnt    = 0;
        m_err    = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_pkt_err", 32'(pkt_err), 32'd0);
        check("rst_gnt_id", 32'(gnt_id), 32'(NR - 1));
      end else begin
        er = (m_locked && !wr_full) ? NR'(1 << m_owner) : '0;
        ew = m_locked && req_valid[m_owner] && !wr_full;
        check("busy", 32'(busy), 32'(m_locked));
        check("gnt_id", 32'(gnt_id), 32'(m_owner));
        check("pkt_err", 32'(pkt_err), 32'(m_err));
        check("req_ready", 32'(req_ready), 32'(er));
        check("wr_en", 32'(wr_en), 32'(ew));
        m_err = 1'b0;
        if (ew) begin
          if (exp_q[m_owner].size() == 0) begin
            check("exp_underflow", 32'd1, 32'd0);
          end else begin
            e = exp_q[m_owner].pop_front();
            check("wr_data", 32'(wr_data), 32'(e[7:0]));
            m_cnt++;
            if (e[8]) m_locked = 1'b0;
            else if (m_cnt == MAXB) begin
              m_locked = 1'b0;
              m_err    = 1'b1;
            end
          end
        end else if (!m_locked && (req_valid != '0)) begin
          found = 1'b0;
          for (int k = 1; k <= NR; k++) begin
            if (!found && req_valid[(m_owner + k) % NR]) begin
              found   = 1'b1;
              m_owner = (m_owner + k) % NR;
            end
          end
          m_locked = 1'b1;
          m_cnt    = 0;
        end
      end
    end
  end

  // Directed scenarios followed by a randomized run.
  initial begin
    int ids[5] = '{0, 1, 2, 3, 0};
    int nw;
    int nr;
    int err0;
    n_chk     = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    en_mask   = '1;
    valid_pct = 100;
    full_pct  = 0;
    full_ctl  = 1'b0;

    // Reset with every requester valid, then round-robin fairness over 3-beat packets.
    send_pkt(0, 3); send_pkt(1, 3); send_pkt(2, 3); send_pkt(3, 3); send_pkt(0, 3);
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk); #1;
    check("t1_first_gnt", 32'(gnt_id), 32'd0);
    check("t1_first_busy", 32'(busy), 32'd1);
    wait_drain(200, "t2");
    check("t2_nwrites", 32'(wlog.size()), 32'd15);
    if (wlog.size() == 15) begin
      for (int j = 0; j < 15; j++) check("t2_order", 32'(wlog[j].d[7:6]), 32'(ids[j/3]));
      for (int p = 1; p < 5; p++) check("t2_pkt_period", wlog[3*p].cyc - wlog[3*(p-1)].cyc, 32'd4);
      check("t2_beat_gap", wlog[1].cyc - wlog[0].cyc, 32'd1);
    end

    // Backpressure for five cycles on beat 2 of 3.
    wlog.delete();
    send_pkt(1, 3);
    wait_writes(1, 50, "t3");
    full_ctl = 1'b1;
    nw = 0;
    nr = 0;
    repeat (5) begin
      @(negedge clk); #1;
      nw += int'(wr_en);
      nr += int'(req_ready != '0);
    end
    full_ctl = 1'b0;
    check("t3_wr_en_while_full", 32'(nw), 32'd0);
    check("t3_ready_while_full", 32'(nr), 32'd0);
    wait_drain(100, "t3");
    check("t3_nwrites", 32'(wlog.size()), 32'd3);
    if (wlog.size() == 3) check("t3_beat2", 32'(wlog[1].d), 32'(last_pkt[1][7:0]));

    // Forced release of a 6-beat packet at four beats.
    wlog.delete();
    err0 = err_seen;
    send_pkt(1, 6);
    wait_drain(200, "t4");
    check("t4_err_pulses", 32'(err_seen - err0), 32'd1);
    check("t4_nwrites", 32'(wlog.size()), 32'd6);
    if (wlog.size() == 6) begin
      check("t4_release_gap", wlog[4].cyc - wlog[3].cyc, 32'd2);
      for (int j = 0; j < 6; j++) check("t4_data", 32'(wlog[j].d), 32'(last_pkt[j][7:0]));
    end

    // Owner stalls mid-packet while requester 2 waits.
    wlog.delete();
    en_mask = 4'b0001;
    send_pkt(0, 3);
    send_pkt(2, 3);
    wait_writes(1, 50, "t5");
    en_mask = 4'b0100;
    nr = 0;
    repeat (10) begin
      @(negedge clk); #1;
      nr += int'(req_ready[2]);
    end
    en_mask = 4'b0101;
    wait_drain(200, "t5");
    check("t5_ready2_during_stall", 32'(nr), 32'd0);
    check("t5_nwrites", 32'(wlog.size()), 32'd6);
    if (wlog.size() == 6)
      for (int j = 0; j < 6; j++) check("t5_order", 32'(wlog[j].d[7:6]), (j < 3) ? 32'd0 : 32'd2);

    // Reset pulsed after beat 1 of requester 3's packet.
    wlog.delete();
    en_mask = 4'b1001;
    send_pkt(3, 3);
    send_pkt(0, 2);
    wait_writes(1, 50, "t6");
    check("t6_first_owner", 32'(wlog[0].d[7:6]), 32'd3);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_wr_en", 32'(wr_en), 32'd0);
    check("t6_req_ready", 32'(req_ready), 32'd0);
    check("t6_pkt_err", 32'(pkt_err), 32'd0);
    check("t6_gnt_id", 32'(gnt_id), 32'd3);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk); #1;
    check("t6_next_gnt", 32'(gnt_id), 32'd0);
    wait_drain(200, "t6");
    check("t6_nwrites", 32'(wlog.size()), 32'd5);
    if (wlog.size() == 5) check("t6_post_reset_owner", 32'(wlog[1].d[7:6]), 32'd0);

    // Randomized traffic with gaps, backpressure and over-long packets.
    en_mask   = '1;
    valid_pct = 70;
    full_pct  = 20;
    for (int p = 0; p < 40; p++) send_pkt(int'($urandom_range(NR - 1)), int'($urandom_range(6, 1)));
    wait_drain(6000, "rand");
    full_pct  = 0;
    valid_pct = 100;
    for (int i = 0; i < NR; i++) check("rand_exp_empty", 32'(exp_q[i].size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
